// File: rtl/lsu_pkg.sv
// Shared constants and store-lane helpers for the load/store unit.
// Access-size encodings follow RV32I funct3; state encodings are fixed.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic m;
        case (op[1:0])
            SZ_H:    m = off[0];
            SZ_W:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] s;
        case (op[1:0])
            SZ_B:    s = STRB_B << off;
            SZ_H:    s = STRB_H << {off[1], 1'b0};
            default: s = STRB_W;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op[1:0])
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load extraction: picks the addressed byte/half out of the
// bus word and sign- or zero-extends it to 32 bits.
module load_ext
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  mem_op,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    // Lane selection by byte offset within the word
    always_comb begin
        byte_sel_s = 8'h00;
        case (offset)
            2'b00:   byte_sel_s = word[7:0];
            2'b01:   byte_sel_s = word[15:8];
            2'b10:   byte_sel_s = word[23:16];
            2'b11:   byte_sel_s = word[31:24];
            default: byte_sel_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_sel_s = word[31:16];
        end else begin
            half_sel_s = word[15:0];
        end
    end

    // Extension according to the access type
    always_comb begin
        data = word;
        case (mem_op)
            OP_B:    data = {{24{byte_sel_s[7]}}, byte_sel_s};
            OP_H:    data = {{16{half_sel_s[15]}}, half_sel_s};
            OP_BU:   data = {24'h000000, byte_sel_s};
            OP_HU:   data = {16'h0000, half_sel_s};
            OP_W:    data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus access, stalls the core until
// completion, and aborts with a bus_err pulse if no ack arrives in time.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_c,
    input  logic [31:0] rD2,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  mem_op,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       off_r;
    logic [2:0]       op_r;
    logic             dbus_req_r, dbus_we_r, bus_err_r;
    logic [31:0]      dbus_addr_r, dbus_wdata_r, rdata_r, ext_s;
    logic [3:0]       dbus_wstrb_r;
    logic             access_s, is_store_s, start_s, timeout_s;

    // Both request lines high is treated as a load
    assign access_s   = mem_re | mem_we;
    assign is_store_s = mem_we & ~mem_re;
    assign misalign   = access_s & is_misaligned(mem_op, alu_c[1:0]);
    assign start_s    = (state_r == ST_IDLE) & access_s & ~misalign;
    assign stall      = start_s | (state_r == ST_REQ);

    load_ext u_load_ext (
        .offset (off_r),
        .mem_op (op_r),
        .word   (dbus_rdata),
        .data   (ext_s)
    );

    // Next-state logic; ack takes priority over the timeout
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dbus_ack) begin
                    next_state_s = ST_DONE;
                end else if (cnt_r == CNT_LIMIT) begin
                    next_state_s = ST_DONE;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latching, wait counter, load capture and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            off_r        <= 2'b00;
            op_r         <= 3'b000;
            dbus_req_r   <= 1'b0;
            dbus_we_r    <= 1'b0;
            dbus_addr_r  <= 32'h0000_0000;
            dbus_wstrb_r <= 4'b0000;
            dbus_wdata_r <= 32'h0000_0000;
            rdata_r      <= 32'h0000_0000;
            bus_err_r    <= 1'b0;
        end else begin
            bus_err_r <= timeout_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        cnt_r        <= '0;
                        off_r        <= alu_c[1:0];
                        op_r         <= mem_op;
                        dbus_req_r   <= 1'b1;
                        dbus_we_r    <= is_store_s;
                        dbus_addr_r  <= {alu_c[31:2], 2'b00};
                        dbus_wstrb_r <= is_store_s ? store_strb(mem_op, alu_c[1:0]) : 4'b0000;
                        dbus_wdata_r <= store_data(mem_op, rD2);
                    end
                end
                ST_REQ: begin
                    if (dbus_ack || timeout_s) begin
                        dbus_req_r   <= 1'b0;
                        dbus_we_r    <= 1'b0;
                        dbus_wstrb_r <= 4'b0000;
                        if (timeout_s) begin
                            rdata_r <= 32'h0000_0000;
                        end else if (!dbus_we_r) begin
                            rdata_r <= ext_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                ST_DONE: cnt_r <= '0;
                default: cnt_r <= '0;
            endcase
        end
    end

    assign dbus_req   = dbus_req_r;
    assign dbus_we    = dbus_we_r;
    assign dbus_addr  = dbus_addr_r;
    assign dbus_wstrb = dbus_wstrb_r;
    assign dbus_wdata = dbus_wdata_r;
    assign rdata      = rdata_r;
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a transaction-level model sets the expected
// outputs every cycle and a single negedge process compares against them.
module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_c, rD2, dbus_rdata;
    logic        mem_re, mem_we, dbus_ack;
    logic [2:0]  mem_op;
    logic        dbus_req, dbus_we, stall, misalign, bus_err;
    logic [31:0] dbus_addr, dbus_wdata, rdata;
    logic [3:0]  dbus_wstrb;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .alu_c(alu_c), .rD2(rD2),
        .mem_re(mem_re), .mem_we(mem_we), .mem_op(mem_op),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_mis, exp_err, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata, model_rdata;
    logic [3:0]  exp_strb;

    int          stall_cnt, req_cnt;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_strb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dbus_req", 32'(dbus_req), 32'(exp_req));
            chk("stall",    32'(stall),    32'(exp_stall));
            chk("misalign", 32'(misalign), 32'(exp_mis));
            chk("bus_err",  32'(bus_err),  32'(exp_err));
            chk("rdata",    rdata,         exp_rdata);
            if (exp_req || !rst_n) begin
                chk("dbus_addr",  dbus_addr,        exp_addr);
                chk("dbus_we",    32'(dbus_we),     32'(exp_we));
                chk("dbus_wstrb", 32'(dbus_wstrb),  32'(exp_strb));
                chk("dbus_wdata", dbus_wdata,       exp_wdata);
            end
        end
    end

    // Activity counters used by the literal checks
    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
        if (dbus_req === 1'b1) begin
            req_cnt++;
            last_addr  = dbus_addr;
            last_wdata = dbus_wdata;
            last_strb  = dbus_wstrb;
        end
    end

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sh, v;
        sh = w >> (8 * off);
        case (op)
            3'b000: begin v = sh & 32'h0000_00FF; if (v >= 32'd128)   v = v - 32'd256;   end
            3'b001: begin v = sh & 32'h0000_FFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b100: v = sh & 32'h0000_00FF;
            3'b101: v = sh & 32'h0000_FFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic idle(input logic ack);
        @(posedge clk); #1;
        mem_re = 1'b0; mem_we = 1'b0; dbus_ack = ack; dbus_rdata = 32'h5A5A_5A5A;
        exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        exp_rdata = model_rdata;
    endtask

    // One access from request through DONE; ack_at < 0 means never ack
    task automatic access(input logic st, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] rword, input int ack_at);
        logic mis, tmo;
        int   nreq;
        mis = (op[1:0] == 2'b01 && addr[0]) || (op[1:0] == 2'b10 && addr[1:0] != 2'b00);
        @(posedge clk); #1;
        mem_re = ~st; mem_we = st; alu_c = addr; rD2 = d; mem_op = op; dbus_ack = 1'b0;
        stall_cnt = 0; req_cnt = 0;
        exp_req = 1'b0; exp_stall = ~mis; exp_mis = mis; exp_err = 1'b0;
        exp_rdata = model_rdata;
        if (mis) begin
            @(posedge clk); #1;
        end else begin
            exp_addr = addr & 32'hFFFF_FFFC;
            exp_we   = st;
            case (op[1:0])
                2'b00: begin exp_strb = 4'd1 << addr[1:0]; exp_wdata = (d & 32'hFF) * 32'h0101_0101; end
                2'b01: begin exp_strb = 4'd3 << addr[1:0]; exp_wdata = (d & 32'hFFFF) * 32'h0001_0001; end
                default: begin exp_strb = 4'hF; exp_wdata = d; end
            endcase
            if (!st) exp_strb = 4'd0;
            tmo  = (ack_at < 0);
            nreq = tmo ? TO : ack_at + 1;
            for (int i = 0; i < nreq; i++) begin
                @(posedge clk); #1;
                exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0;
                dbus_ack   = (i == ack_at);
                dbus_rdata = (i == ack_at) ? rword : (32'hDEAD_BEEF ^ 32'(i));
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0; dbus_rdata = 32'h0BAD_F00D;
            exp_req = 1'b0; exp_stall = 1'b0; exp_err = tmo;
            if (tmo) model_rdata = 32'h0;
            else if (!st) model_rdata = load_value(op, addr[1:0], rword);
            exp_rdata = model_rdata;
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_re = 1'b0; mem_we = 1'b0; alu_c = 32'h0; rD2 = 32'h0;
        mem_op = 3'b000; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        model_rdata = 32'h0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
        exp_rdata = 32'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_strb = 4'h0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1'b0);

        access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0);
        @(negedge clk);
        chk("sb_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("sb_addr_lit",  last_addr,        32'h0000_1000);
        chk("sb_strb_lit",  32'(last_strb),   32'h0000_0008);
        chk("sb_wdata_lit", last_wdata,       32'hABAB_ABAB);

        access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        @(negedge clk); chk("lh_lit", rdata, 32'hFFFF_8001);
        access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
        @(negedge clk); chk("lhu_lit", rdata, 32'h0000_8001);
        access(1'b0, 3'b000, 32'h0000_2000, 32'h0, 32'h8001_1234, 2);
        @(negedge clk); chk("lb_lit", rdata, 32'h0000_0034);
        access(1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8001_1234, 0);
        access(1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h8001_1234, 0);
        @(negedge clk); chk("lbu_lit", rdata, 32'h0000_0080);
        access(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h1357_9BDF, 3);
        access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 1);
        @(negedge clk);
        chk("sh_strb_lit",  32'(last_strb), 32'h0000_000C);
        chk("sh_wdata_lit", last_wdata,     32'h5678_5678);
        access(1'b1, 3'b010, 32'h0000_2008, 32'h1122_3344, 32'h0, 0);
        access(1'b1, 3'b000, 32'h0000_2009, 32'h0000_00C3, 32'h0, 0);
        idle(1'b0);

        access(1'b0, 3'b010, 32'h0000_2001, 32'h0, 32'h0, 0);
        @(negedge clk); chk("lw_mis_req_cnt", 32'(req_cnt), 32'd0);
        access(1'b0, 3'b001, 32'h0000_2003, 32'h0, 32'h0, 0);
        idle(1'b1);
        idle(1'b0);

        access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, -1);
        @(negedge clk);
        chk("to_req_cycles", 32'(req_cnt), 32'd16);
        chk("to_bus_err",    32'(bus_err), 32'd1);
        chk("to_rdata",      rdata,        32'h0);
        idle(1'b0);
        access(1'b0, 3'b010, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, TO - 1);
        @(negedge clk);
        chk("edge_ack_rdata", rdata,        32'hCAFE_F00D);
        chk("edge_ack_err",   32'(bus_err), 32'd0);
        idle(1'b0);

        // Reset while the bus request is outstanding, then a late ack
        @(posedge clk); #1;
        mem_re = 1'b1; mem_we = 1'b0; alu_c = 32'h0000_3008; mem_op = 3'b010;
        exp_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp_req = 1'b1; exp_addr = 32'h0000_3008; exp_we = 1'b0;
            exp_strb = 4'h0; exp_wdata = 32'h0;
        end
        #1;
        rst_n = 1'b0; mem_re = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; model_rdata = 32'h0; exp_rdata = 32'h0;
        exp_addr = 32'h0; exp_we = 1'b0; exp_strb = 4'h0; exp_wdata = 32'h0;
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1'b1);
        dbus_rdata = 32'h1234_5678;
        idle(1'b0);
        @(negedge clk);
        chk("rst_late_ack_rdata", rdata,         32'h0);
        chk("rst_late_ack_req",   32'(dbus_req), 32'd0);
        chk("rst_late_ack_err",   32'(bus_err),  32'd0);
        idle(1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
